// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch constants, fetch FSM states and the buffer entry type
`ifndef DATA_W
`define DATA_W 32
`endif
package fetch_pkg;
  localparam logic [`DATA_W-1:0] PC_STEP = 4;
  localparam logic [`DATA_W-1:0] RESET_PC_DEFAULT = '0;
  localparam int BUF_DEPTH = 2;
  typedef enum logic {RUN, DRAIN} fetch_state_t;
  typedef struct packed {
    logic [`DATA_W-1:0] pc;
    logic [`DATA_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: two-entry registered {pc, instr} FIFO with push, pop, flush and occupancy count
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic rd_q, rd_d, wr_q, wr_d;
  logic [1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = push_entry;
    rd_d = flush ? 1'b0 : rd_q ^ pop;
    wr_d = flush ? 1'b0 : wr_q ^ push;
    cnt_d = flush ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
    head_o = mem_q[rd_q];
    count_o = cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
    mem_q <= mem_d;
  end
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: credit-limited instruction fetch with redirect flush and stale-response drain
`ifndef DATA_W
`define DATA_W 32
`endif
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [`DATA_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int BUF_DEPTH = fetch_pkg::BUF_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid_i,
  input  logic [`DATA_W-1:0] redirect_pc_i,
  output logic               imem_req_o,
  output logic [`DATA_W-1:0] imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic [`DATA_W-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  output logic [`DATA_W-1:0] instr_o,
  output logic [`DATA_W-1:0] instr_pc_o,
  input  logic               instr_ready_i
);
  fetch_state_t state_q, state_d;
  logic [`DATA_W-1:0] fpc_q, fpc_d, ifl_pc_q, ifl_pc_d;
  logic ifl_q, ifl_d, pop, push, gnt_acc;
  logic [1:0] count;
  fetch_entry_t head, wr_entry;
  always_comb begin
    instr_valid_o = !rst && !redirect_valid_i && count != 2'd0;
    pop = instr_valid_o && instr_ready_i;
    // credit: buffered + in-flight, less what leaves this cycle, must leave room
    imem_req_o = !rst && !redirect_valid_i &&
                 ({1'b0, count} + {2'b0, ifl_q} < 3'(BUF_DEPTH) + {2'b0, pop});
    imem_addr_o = fpc_q;
    gnt_acc = imem_req_o && imem_gnt_i;
    push = ifl_q && state_q == RUN && !redirect_valid_i;
    wr_entry = '{pc: ifl_pc_q, instr: imem_rdata_i};
    fpc_d = redirect_valid_i ? redirect_pc_i & ~`DATA_W'(3) : gnt_acc ? fpc_q + PC_STEP : fpc_q;
    ifl_d = gnt_acc;
    ifl_pc_d = fpc_q;
    state_d = redirect_valid_i && (ifl_q || gnt_acc) ? DRAIN : RUN;
    instr_o = head.instr;
    instr_pc_o = head.pc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fpc_q <= RESET_PC;
      ifl_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q <= fpc_d;
      ifl_q <= ifl_d;
    end
    ifl_pc_q <= ifl_pc_d;
  end
  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid_i),
    .push       (push),
    .pop        (pop),
    .push_entry (wr_entry),
    .head_o     (head),
    .count_o    (count)
  );
endmodule
